// File: rtl/ova_pkg.sv
// Shared types and helpers for the OVA output drain and quantising stages.
package ova_pkg;

  typedef enum logic {IDLE, STREAM} ova_so_state_t;

  // Edge length of the overlap-added frame built from root x root tiles.
  function automatic int ova_out_size(int root, int size, int overlap);
    return root * size - (root - 1) * overlap;
  endfunction

endpackage

// File: rtl/ova_stream_out_if.sv
// Pixel stream handshake leaving the OVA drain.
interface ova_stream_out_if
  import ova_pkg::*;
#(
  parameter int OUT_W = 16
);
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last_col;
  logic             m_last;

  modport master (output m_valid, m_data, m_last_col, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last_col, m_last, output m_ready);
endinterface

// File: rtl/ova_sat_round.sv
// Combinational 32-bit -> OUT_W round-half-up and saturate.
module ova_sat_round
  import ova_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic [31:0]      x,
  output logic [OUT_W-1:0] y
);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

  logic signed [32:0] xe, r;
  assign xe = {x[31], x};

  // 33-bit sum keeps the rounding bias from wrapping at the positive limit.
  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
      assign r = (xe + HALF) >>> SHIFT;
    end else begin : g_pass
      assign r = xe;
    end
  endgenerate

  always_comb begin
    if (r > MAXV)      y = MAXV[OUT_W-1:0];
    else if (r < MINV) y = MINV[OUT_W-1:0];
    else               y = r[OUT_W-1:0];
  end
endmodule

// File: rtl/ova_stream_out.sv
// Shadows one OVA frame and drains its cropped, quantised pixels row-major.
module ova_stream_out
  import ova_pkg::*;
#(
  parameter int NUM_BLOCK_ROOT = 4,
  parameter int SIZE           = 4,
  parameter int OVERLAP        = 1,
  parameter int CROP           = 1,
  parameter int SHIFT          = 0,
  parameter int OUT_W          = 16,
  localparam int OUT_SIZE      = ova_out_size(NUM_BLOCK_ROOT, SIZE, OVERLAP)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    frame_valid,
  input  logic [OUT_SIZE-1:0][OUT_SIZE-1:0][31:0] frame_data,
  output logic                                    frame_ready,
  output logic                                    busy,
  ova_stream_out_if.master                        m
);
  localparam int C  = OUT_SIZE - 2 * CROP;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int IW = $clog2(OUT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(C - 1);
  localparam logic [IW-1:0] CR   = IW'(CROP);

  ova_so_state_t state, state_nxt;
  logic [CW-1:0] row, col;
  logic [IW-1:0] ri, ci;
  logic [OUT_SIZE-1:0][OUT_SIZE-1:0][31:0] shadow;
  logic [OUT_W-1:0] pix;
  logic take, beat, at_end;

  assign take   = (state == IDLE) && frame_valid;
  assign beat   = (state == STREAM) && m.m_ready;
  assign at_end = (row == LAST) && (col == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_ready = 1'b0;
    busy        = 1'b0;
    m.m_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        frame_ready = ~reset;
        if (frame_valid) state_nxt = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        m.m_valid = 1'b1;
        if (m.m_ready && at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both indices wrap explicitly so row/col are back at the origin in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      col    <= '0;
      shadow <= '0;
    end else if (take) begin
      row    <= '0;
      col    <= '0;
      shadow <= frame_data;
    end else if (beat) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign ri = IW'(row) + CR;
  assign ci = IW'(col) + CR;

  ova_sat_round #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_round (
    .x (shadow[ri][ci]),
    .y (pix)
  );

  assign m.m_data     = m.m_valid ? pix : '0;
  assign m.m_last_col = m.m_valid && (col == LAST);
  assign m.m_last     = m.m_valid && at_end;
endmodule

// File: tb/tb_ova_stream_out.sv
// Directed scoreboard bench for ova_stream_out (SHIFT=0 and SHIFT=4 copies in lockstep).
module tb_ova_stream_out;
  localparam int OS = 13;
  localparam int CR = 1;

  typedef struct { int data; logic lc; logic l; } exp_t;

  logic clk = 0, reset = 0, frame_valid = 0, m_ready = 0;
  logic [OS-1:0][OS-1:0][31:0] fd = '0;
  logic fr0, fr4, busy0, busy4;
  exp_t sb0[$], sb4[$];
  int got0[$], got4[$];
  int n_cmp = 0, n_bad = 0;
  int span, bub;

  ova_stream_out_if #(.OUT_W(16)) if0 ();
  ova_stream_out_if #(.OUT_W(16)) if4 ();
  assign if0.m_ready = m_ready;
  assign if4.m_ready = m_ready;

  ova_stream_out #(.SHIFT(0)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(fd),
    .frame_ready(fr0), .busy(busy0), .m(if0));
  ova_stream_out #(.SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(fd),
    .frame_ready(fr4), .busy(busy4), .m(if4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(logic [31:0] x, int sh);
    longint v = longint'($signed(x));
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic load_ramp(input int off);
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++) fd[r][c] = 32'(r * 13 + c + off);
  endtask

  task automatic push_frame();
    for (int r = CR; r < OS - CR; r++)
      for (int c = CR; c < OS - CR; c++) begin
        sb0.push_back('{model(fd[r][c], 0), c == OS-CR-1, (r == OS-CR-1) && (c == OS-CR-1)});
        sb4.push_back('{model(fd[r][c], 4), c == OS-CR-1, (r == OS-CR-1) && (c == OS-CR-1)});
      end
  endtask

  task automatic start_frame(input bit hold);
    @(negedge clk);
    chk("idle_rdy", fr0, 1);
    m_ready = 0; frame_valid = 1; push_frame();
    @(negedge clk);
    chk("lat_valid", if0.m_valid, 1);
    chk("lat_busy", busy0, 1);
    chk("lat_rdy", fr0, 0);
    if (!hold) frame_valid = 0;
  endtask

  // pat 0: m_ready high; pat 1: 1,0,0,1 repeating. inj>0: new frame offered on that cycle.
  task automatic drain(input int nb, input int pat, input int inj, output int sp, output int bb);
    exp_t e, e4;
    int cyc = 0, got = 0, first = -1, last = -1;
    logic stall = 0, post = 0, hl = 0, hlc = 0;
    logic [15:0] hd = '0;
    got0.delete(); got4.delete(); bb = 0;
    while (got < nb && cyc < nb * 4 + 50) begin
      @(negedge clk); cyc++;
      if (cyc == inj) begin load_ramp(1000); push_frame(); frame_valid = 1; end
      m_ready = (pat == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      if (post) begin
        chk("rdy_after_last", fr0, 1);
        chk("bubble_valid", if0.m_valid, 0);
        post = 0;
      end
      if (stall) begin
        chk("stall_valid", if0.m_valid, 1);
        chk("stall_data", if0.m_data, hd);
        chk("stall_last", if0.m_last, hl);
        chk("stall_lastcol", if0.m_last_col, hlc);
      end
      if (got > 0 && !if0.m_valid) bb++;
      stall = if0.m_valid && !m_ready;
      hd = if0.m_data; hl = if0.m_last; hlc = if0.m_last_col;
      if (if0.m_valid && m_ready) begin
        chk("sb_nonempty", sb0.size() > 0 && sb4.size() > 0, 1);
        e = '{0, 1'b0, 1'b0}; e4 = e;
        if (sb0.size() > 0) e = sb0.pop_front();
        if (sb4.size() > 0) e4 = sb4.pop_front();
        chk("data", $signed(if0.m_data), e.data);
        chk("last_col", if0.m_last_col, e.lc);
        chk("last", if0.m_last, e.l);
        chk("valid4", if4.m_valid, 1);
        chk("data4", $signed(if4.m_data), e4.data);
        got0.push_back(int'($signed(if0.m_data)));
        got4.push_back(int'($signed(if4.m_data)));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        if (e.l) post = 1;
        if (got == nb) frame_valid = 0;
      end
    end
    chk("beats", got, nb);
    if (post) begin
      @(negedge clk);
      chk("rdy_after_last", fr0, 1);
      chk("bubble_valid", if0.m_valid, 0);
    end
    sp = last - first + 1;
  endtask

  initial begin
    // reset values
    #1 reset = 1;
    #2;
    chk("rst_valid", if0.m_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_data", if0.m_data, 0);
    chk("rst_last", if0.m_last, 0);
    chk("rst_lastcol", if0.m_last_col, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    #1 chk("rst_rdy", fr0, 1);

    // ramp frame, m_ready held high
    load_ramp(0);
    start_frame(0);
    drain(121, 0, 0, span, bub);
    chk("span_full", span, 121);
    if (got0.size() == 121) begin
      chk("first_px", got0[0], 14);
      chk("lastcol_px", got0[10], 24);
      chk("last_px", got0[120], 154);
    end

    // same frame with stalls
    start_frame(0);
    drain(121, 1, 0, span, bub);
    if (got0.size() == 121) begin
      chk("stall_first", got0[0], 14);
      chk("stall_lastpx", got0[120], 154);
    end

    // saturation and rounding corners
    load_ramp(0);
    fd[1][1] = 32'h0001_0000;
    fd[1][2] = 32'hFFFE_0000;
    fd[1][3] = 32'd24;
    fd[2][2] = 32'h7FFF_FFFF;
    fd[3][3] = 32'hFFFF_FFE8;
    start_frame(0);
    drain(121, 0, 0, span, bub);
    if (got0.size() == 121) begin
      chk("sat_pos", got0[0], 32767);
      chk("sat_neg", got0[1], -32768);
      chk("pass24", got0[2], 24);
      chk("s4_pos", got4[0], 4096);
      chk("s4_neg", got4[1], -8192);
      chk("s4_round", got4[2], 2);
      chk("s4_nowrap", got4[12], 32767);
      chk("s4_negrnd", got4[24], -1);
    end

    // frame offered mid-stream must wait for the bubble
    load_ramp(0);
    start_frame(0);
    drain(242, 0, 10, span, bub);
    chk("inj_span", span, 243);
    chk("inj_bubbles", bub, 1);

    // reset mid-frame
    load_ramp(0);
    start_frame(0);
    drain(50, 0, 0, span, bub);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", if0.m_valid, 1);
    reset = 1;
    #1;
    chk("mid_rst_valid", if0.m_valid, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_data", if0.m_data, 0);
    sb0.delete(); sb4.delete();
    @(negedge clk);
    reset = 0;
    #1 chk("mid_rst_rdy", fr0, 1);
    start_frame(0);
    drain(121, 0, 0, span, bub);
    if (got0.size() == 121) chk("after_rst_first", got0[0], 14);

    // back-to-back frames with frame_valid held
    load_ramp(0);
    start_frame(1);
    push_frame();
    drain(242, 0, 0, span, bub);
    chk("b2b_span", span, 243);
    chk("b2b_bubbles", bub, 1);

    chk("sb_left", sb0.size() + sb4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
